// File: rtl/truth_table_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer_pkg
//  Description : Shared types and constants for the truth-table sequencer.
//                Provides the sequencer state encoding, the default input
//                count and derived vector count, and the settle-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    localparam int N_IN_DEF = 4;
    localparam int N_VEC    = 1 << N_IN_DEF;

    // Settle counter holds SETTLE-1, and SETTLE is at most 255.
    localparam int CNT_W    = 8;

    // Number of input combinations for an n-input block.
    function automatic int n_vec(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sequencer_tt_compare.sv
`default_nettype none
// ============================================================================
//  Module      : tt_compare
//  Description : Combinational comparison of a captured truth table against
//                a golden word: mismatch count and lowest mismatching index.
//  Ports       : table_i      captured truth table
//                expected_i   golden truth table
//                pass_o       1 when the tables are identical
//                err_count_o  number of mismatching bits
//                fail_idx_o   lowest mismatching index, 0 when none
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_compare #(
    parameter int N_IN = 4
) (
    input  logic [(1<<N_IN)-1:0] table_i,
    input  logic [(1<<N_IN)-1:0] expected_i,
    output logic                 pass_o,
    output logic [N_IN:0]        err_count_o,
    output logic [N_IN-1:0]      fail_idx_o
);

    localparam int NV = 1 << N_IN;

    logic [NV-1:0] w_diff;

    assign w_diff = table_i ^ expected_i;
    assign pass_o = ~|w_diff;

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        err_count_o = '0;
        fail_idx_o  = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                err_count_o = err_count_o + (N_IN+1)'(1);
                fail_idx_o  = N_IN'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer
//  Description : Exhaustive-stimulus controller for a small combinational
//                block. Walks VEC through every input combination, holds each
//                for SETTLE cycles, captures G into a truth table and compares
//                it against a golden word at the end of the run.
//  Ports       : clk_i        rising-edge clock
//                rst_ni       asynchronous active-low reset
//                start_i      begin a run (honoured only in IDLE)
//                abort_i      cancel a run in progress, no DONE
//                expected_i   golden truth table, sampled in the DONE cycle
//                g_i          output of the block under test
//                vec_o        drive to block inputs {A,B,C,D}
//                busy_o       run in progress (through the DONE cycle)
//                done_o       one-cycle end-of-run pulse
//                table_o      captured truth table
//                pass_o       table_o == expected_i
//                err_count_o  number of mismatching bits
//                fail_idx_o   lowest mismatching index, 0 on pass
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [(1<<N_IN)-1:0] expected_i,
    input  logic                 g_i,
    output logic [N_IN-1:0]      vec_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [(1<<N_IN)-1:0] table_o,
    output logic                 pass_o,
    output logic [N_IN:0]        err_count_o,
    output logic [N_IN-1:0]      fail_idx_o
);

    localparam int                NV       = (N_IN == N_IN_DEF) ? N_VEC : n_vec(N_IN);
    localparam logic [CNT_W-1:0]  C_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]   C_LAST   = N_IN'(NV - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_IN-1:0]  vec_q;
    logic             busy_q;
    logic             done_q;
    logic [NV-1:0]    table_q;
    logic             pass_q;
    logic [N_IN:0]    err_q;
    logic [N_IN-1:0]  fidx_q;

    logic             w_pass;
    logic [N_IN:0]    w_err;
    logic [N_IN-1:0]  w_fidx;

    tt_compare #(
        .N_IN (N_IN)
    ) u_cmp (
        .table_i     (table_q),
        .expected_i  (expected_i),
        .pass_o      (w_pass),
        .err_count_o (w_err),
        .fail_idx_o  (w_fidx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && (state_q != S_IDLE)) begin
                // Partial table is kept for inspection after an abort.
                state_q <= S_IDLE;
                vec_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        vec_q <= '0;
                        if (start_i && !abort_i) begin
                            state_q <= S_DRIVE;
                            cnt_q   <= C_RELOAD;
                            busy_q  <= 1'b1;
                            table_q <= '0;
                            pass_q  <= 1'b0;
                            err_q   <= '0;
                            fidx_q  <= '0;
                        end
                    end
                    S_DRIVE: begin
                        if (cnt_q == '0) begin
                            table_q[vec_q] <= g_i;
                            if (vec_q == C_LAST) begin
                                state_q <= S_FINISH;
                                vec_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                vec_q <= vec_q + N_IN'(1);
                                cnt_q <= C_RELOAD;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_FINISH: begin
                        // table_q now includes the final sample.
                        pass_q  <= w_pass;
                        err_q   <= w_err;
                        fidx_q  <= w_fidx;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        vec_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign vec_o       = vec_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign table_o     = table_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_idx_o  = fidx_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sequencer
//  Description : Self-checking bench for truth_table_sequencer. The block
//                under test is modelled as a truth-table word indexed by VEC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

    localparam int S0 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'h0;
    logic        g;
    logic [3:0]  vec;
    logic        busy, done, pass;
    logic [15:0] tbl;
    logic [4:0]  err;
    logic [3:0]  fidx;

    logic        start1 = 1'b0;
    logic        g1;
    logic [3:0]  vec1;
    logic        busy1, done1, pass1;
    logic [15:0] tbl1;
    logic [4:0]  err1;
    logic [3:0]  fidx1;

    logic [15:0] fn_word = 16'h0;
    logic        stuck = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign g  = stuck ? 1'b1 : fn_word[vec];
    assign g1 = fn_word[vec1];

    truth_table_sequencer #(.N_IN(4), .SETTLE(S0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .expected_i(expected), .g_i(g), .vec_o(vec), .busy_o(busy),
        .done_o(done), .table_o(tbl), .pass_o(pass), .err_count_o(err),
        .fail_idx_o(fidx)
    );

    truth_table_sequencer #(.N_IN(4), .SETTLE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(1'b0),
        .expected_i(expected), .g_i(g1), .vec_o(vec1), .busy_o(busy1),
        .done_o(done1), .table_o(tbl1), .pass_o(pass1), .err_count_o(err1),
        .fail_idx_o(fidx1)
    );

    // Reference: G = A&B | C&D with A = VEC[3], D = VEC[0].
    function automatic logic [15:0] golden_fn();
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) begin
            logic a, b, c, d;
            {a, b, c, d} = 4'(i);
            w[i] = (a & b) | (c & d);
        end
        return w;
    endfunction

    function automatic int count_diff(input logic [15:0] x, input logic [15:0] y);
        int n = 0;
        for (int i = 0; i < 16; i++) if (x[i] != y[i]) n++;
        return n;
    endfunction

    function automatic int first_diff(input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < 16; i++) if (x[i] != y[i]) return i;
        return 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        total++; if (vec !== 4'h0)   begin bad++; $display("FAIL reset_vec: got %h want 0", vec); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (tbl !== 16'h0)  begin bad++; $display("FAIL reset_table: got %h want 0000", tbl); end
        total++; if (pass !== 1'b0)  begin bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        total++; if (err !== 5'd0)   begin bad++; $display("FAIL reset_err: got %0d want 0", err); end
        total++; if (fidx !== 4'd0)  begin bad++; $display("FAIL reset_fidx: got %0d want 0", fidx); end
    endtask

    // Full run on the SETTLE=2 instance with result checks.
    task automatic do_run(input logic [15:0] fn, input logic stk,
                          input logic [15:0] exp, input string nm);
        int cyc = 0;
        bit seq_ok = 1;
        bit seen = 0;
        logic [15:0] rt;
        logic        e_pass;
        int          e_err, e_idx;
        fn_word  = fn;
        stuck    = stk;
        expected = exp;
        rt     = stk ? 16'hFFFF : fn;
        e_err  = count_diff(rt, exp);
        e_idx  = first_diff(rt, exp);
        e_pass = (rt == exp);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                if (vec !== 4'h0 || busy !== 1'b1) seq_ok = 0;
            end else begin
                if (cyc >= 16 * S0 || vec !== 4'(cyc / S0) || busy !== 1'b1) seq_ok = 0;
                @(posedge clk);
                cyc++;
            end
        end
        total++;
        if (!seen || cyc + 1 != 16 * S0 + 1) begin
            bad++; $display("FAIL %s_done_cycle: got %0d (seen=%0d) want %0d", nm, cyc + 1, seen, 16 * S0 + 1);
        end
        total++; if (!seq_ok) begin bad++; $display("FAIL %s_vec_seq: got bad sequence want 0..15 x%0d", nm, S0); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_after_done: got done=%b busy=%b want 0 0", nm, done, busy); end
        total++; if (tbl !== rt) begin bad++; $display("FAIL %s_table: got %h want %h", nm, tbl, rt); end
        total++; if (pass !== e_pass) begin bad++; $display("FAIL %s_pass: got %b want %b", nm, pass, e_pass); end
        total++; if (err !== 5'(e_err)) begin bad++; $display("FAIL %s_err: got %0d want %0d", nm, err, e_err); end
        total++; if (fidx !== 4'(e_idx)) begin bad++; $display("FAIL %s_fidx: got %0d want %0d", nm, fidx, e_idx); end
        stuck = 1'b0;
    endtask

    task automatic test_golden();
        do_run(golden_fn(), 1'b0, 16'hF888, "golden");
    endtask

    task automatic test_mismatch();
        do_run(golden_fn(), 1'b0, 16'hF889, "mis0");
        do_run(golden_fn(), 1'b0, 16'hF8C8, "mis6");
    endtask

    task automatic test_stuck();
        do_run(golden_fn(), 1'b1, 16'hF888, "stuck1");
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            logic [15:0] fn, ex;
            fn = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       ex = fn;
                1:       ex = fn ^ (16'h1 << $urandom_range(0, 15));
                default: ex = 16'($urandom);
            endcase
            do_run(fn, 1'b0, ex, "rand");
        end
    endtask

    task automatic wait_vec(input logic [3:0] v, output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (vec === v) ok = 1;
            n++;
        end
    endtask

    task automatic no_done_window(input string nm);
        bit saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1;
        end
        total++; if (saw) begin bad++; $display("FAIL %s_no_done: got done/busy activity want none", nm); end
    endtask

    task automatic test_abort();
        bit ok;
        fn_word = golden_fn();
        expected = 16'hF888;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_vec(4'd3, ok);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        total++; if (!ok || vec !== 4'd3 || busy !== 1'b1) begin bad++; $display("FAIL busy_start: got vec=%0d busy=%b want vec=3 busy=1", vec, busy); end
        wait_vec(4'd5, ok);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        total++; if (!ok || vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort: got vec=%0d busy=%b done=%b want 0 0 0", vec, busy, done);
        end
        no_done_window("abort");
        do_run(golden_fn(), 1'b0, 16'hF888, "after_abort");
    endtask

    task automatic test_async_reset();
        bit ok;
        fn_word = golden_fn();
        expected = 16'hF888;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_vec(4'd9, ok);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        total++; if (!ok || vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tbl !== 16'h0 ||
                     pass !== 1'b0 || err !== 5'd0 || fidx !== 4'd0) begin
            bad++; $display("FAIL async_reset: got vec=%0d busy=%b done=%b table=%h want all zero", vec, busy, done, tbl);
        end
        #2 rst_n = 1'b1;
        no_done_window("rst");
        do_run(golden_fn(), 1'b0, 16'hF888, "after_rst");
    endtask

    task automatic test_settle1();
        int cyc = 0;
        bit seen = 0;
        fn_word = golden_fn();
        expected = 16'hF888;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (done1) seen = 1;
            else begin @(posedge clk); cyc++; end
        end
        total++; if (!seen || cyc + 1 != 17) begin bad++; $display("FAIL s1_done_cycle: got %0d want 17", cyc + 1); end
        @(negedge clk);
        total++; if (tbl1 !== 16'hF888 || pass1 !== 1'b1 || err1 !== 5'd0 || fidx1 !== 4'd0) begin
            bad++; $display("FAIL s1_result: got table=%h pass=%b err=%0d want F888 1 0", tbl1, pass1, err1);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_stuck();
        test_random();
        test_abort();
        test_async_reset();
        test_settle1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Self-checking exhaustive-stimulus controller for a small combinational block with inputs A..D and output G.
- On START, it walks the input vector through every combination 0..2^N_IN-1 and holds each vector for SETTLE cycles.
- It samples G into a captured truth table and, at the end, compares that table against an EXPECTED word.
- It replaces hand-written vector lists with a synthesizable sequencer, so the same check runs in simulation or on board.

Parameters:
- N_IN, 4, number of DUT inputs; VEC[N_IN-1] maps to A and VEC[0] to D.
- SETTLE, 2, cycles each vector is held before G is sampled; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  begin a run; honoured only in IDLE
- ABORT  input  1  cancel the run; returns to IDLE with no DONE
- EXPECTED  input  2^N_IN  golden truth table; bit i is the expected G for VEC==i; sampled on DONE cycle
- G  input  1  DUT output
- VEC  output  N_IN  drive to DUT inputs {A,B,C,D}
- BUSY  output  1  high from the cycle after START is accepted until the DONE cycle inclusive
- DONE  output  1  one-cycle pulse at the end of the run
- TABLE  output  2^N_IN  captured G values; bit i is G sampled while VEC==i
- PASS  output  1  TABLE==EXPECTED; valid from DONE, held until next START
- ERR_COUNT  output  N_IN+1  number of mismatching bits; valid from DONE
- FAIL_IDX  output  N_IN  lowest mismatching index; 0 when PASS

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; all outputs 0 (VEC, BUSY, DONE, TABLE, PASS, ERR_COUNT, FAIL_IDX). Reset mid-run takes effect immediately and no DONE is produced.
- States and transitions:
  - IDLE -> DRIVE on START.
  - DRIVE -> DRIVE on the next vector.
  - DRIVE -> FINISH after the last vector.
  - FINISH -> IDLE.
- IDLE:
  - VEC holds 0.
  - START high: next cycle enters DRIVE with VEC=0, settle counter = SETTLE-1, TABLE cleared, and PASS/ERR_COUNT/FAIL_IDX cleared.
- DRIVE:
  - VEC is held and the counter decrements each cycle.
  - In the cycle where counter==0, G is registered into TABLE[VEC] at that edge.
  - If VEC != 2^N_IN-1: VEC increments and the counter reloads SETTLE-1.
  - Otherwise: next state FINISH and VEC returns to 0.
- FINISH (1 cycle):
  - DONE=1 and BUSY=1.
  - PASS, ERR_COUNT and FAIL_IDX are registered from the final TABLE vs EXPECTED. The comparison uses the TABLE value including the last sample, i.e. the comparison is registered one cycle after the last sample.
  - Next state IDLE, BUSY=0.
- Timing: each vector occupies exactly SETTLE cycles. With START accepted at edge 0, DONE is high in cycle 2^N_IN*SETTLE+1 (33 for the defaults).
- ABORT:
  - Valid in DRIVE or FINISH; takes priority over all transitions.
  - Next cycle: IDLE, VEC=0, BUSY=0, DONE=0; TABLE keeps partial contents.
  - ABORT and START together in IDLE: START is ignored.
- START while BUSY: ignored, no restart.
- ERR_COUNT: popcount of (TABLE ^ EXPECTED); width N_IN+1 so that 2^N_IN fits (e.g. 16 fits in 5 bits).
- FAIL_IDX: priority encode of the lowest set bit of the XOR.
- VEC wraps only via the explicit return to 0; it never increments past 2^N_IN-1.

Decomposition:
- Shared package:
  - state enum localparams S_IDLE, S_DRIVE, S_FINISH.
  - derived localparam N_VEC = 2^N_IN.
  - counter width for SETTLE (8 bits).
- Sub-module tt_compare: combinational XOR, popcount and lowest-index encoder, parameterised by N_IN. Its outputs are registered in FINISH.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles, then release -> VEC=0, BUSY=0, DONE=0, TABLE=0000, PASS=0, ERR_COUNT=0.
- Golden pass: DUT model G=A&B|C&D, EXPECTED=16'hF888, SETTLE=2, START pulse -> VEC steps 0..15, each value held 2 cycles; DONE in cycle 33; TABLE=F888, PASS=1, ERR_COUNT=0, FAIL_IDX=0.
- Single mismatch: same DUT, EXPECTED=16'hF889 -> PASS=0, ERR_COUNT=1, FAIL_IDX=0; with EXPECTED=16'hF8C8 -> ERR_COUNT=1, FAIL_IDX=6.
- Stuck-at-1: G tied to 1, EXPECTED=F888 -> TABLE=FFFF, ERR_COUNT=9, FAIL_IDX=0, PASS=0.
- Abort and busy-start:
  - Pulse START again while VEC=3 -> ignored, run continues.
  - Assert ABORT while VEC=5 -> next cycle IDLE, VEC=0, BUSY=0, no DONE.
  - New START -> full run completes with the correct results.
- Async reset mid-run: drop RST_N for half a cycle while VEC=9 -> all outputs 0 immediately, no DONE; a restart passes. Also run SETTLE=1 -> DONE in cycle 17.
